// File: rtl/final_fpga_cpu_oci_dct_packer.sv
// Direct-branch trace packer: shifts 2-bit taken/not-taken codes into a
// compression buffer and closes it into a 36-bit frame on the ITM handshake.
module final_fpga_cpu_oci_dct_packer #(
   parameter int DEPTH   = 15,
   parameter int SAT_MAX = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        trace_en,
   input  logic        dct_valid,
   input  logic        dct_taken,
   input  logic        flush,
   input  logic        itm_ready,
   output logic        itm_valid,
   output logic [35:0] itm_frame,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count,
   output logic [7:0]  drop_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FILL = 2'b01,
      PEND = 2'b10
   } state_e;

   localparam logic [3:0] DEPTH_C = 4'(DEPTH);
   localparam logic [7:0] SAT_C   = 8'(SAT_MAX);

   state_e      state_q, state_d;
   logic [29:0] buf_q, buf_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic        pflush_q, pflush_d;
   logic        vld_q, vld_d;
   logic [35:0] frame_q, frame_d;
   logic [7:0]  drop_q, drop_d;

   logic        pend_s, free_s, accept_s, drop_s, close_s, load_s;
   logic [29:0] buf_nx_s;
   logic [3:0]  cnt_nx_s;

   function automatic logic [1:0] dct_code(input logic taken);
      return taken ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [1:0] frame_type(input logic ovf, input logic fl);
      if (ovf) begin
         return 2'b11;
      end else if (fl) begin
         return 2'b10;
      end else begin
         return 2'b01;
      end
   endfunction

   // Next-state logic: event acceptance, close decision and output register load.
   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      pflush_d = pflush_q;
      frame_d  = frame_q;
      drop_d   = drop_q;
      load_s   = 1'b0;
      buf_nx_s = buf_q;
      cnt_nx_s = cnt_q;

      pend_s   = (state_q == PEND);
      free_s   = ~vld_q | itm_ready;
      accept_s = trace_en & dct_valid & ~pend_s;
      drop_s   = trace_en & dct_valid & pend_s;

      if (accept_s) begin
         buf_nx_s = {buf_q[27:0], dct_code(dct_taken)};
         cnt_nx_s = cnt_q + 4'd1;
      end else begin
         buf_nx_s = buf_q;
         cnt_nx_s = cnt_q;
      end
      close_s = ~pend_s & ((cnt_nx_s == DEPTH_C) | (flush & (cnt_nx_s != 4'd0)));

      if (drop_s && (drop_q != SAT_C)) begin
         drop_d = drop_q + 8'd1;
      end else begin
         drop_d = drop_q;
      end

      case (state_q)
         PEND: begin
            // Events lost while this frame waited mark it as overflowed.
            if (free_s) begin
               frame_d  = {frame_type(ovf_q | drop_s, pflush_q | flush), cnt_q, buf_q};
               load_s   = 1'b1;
               buf_d    = 30'd0;
               cnt_d    = 4'd0;
               ovf_d    = 1'b0;
               pflush_d = 1'b0;
               state_d  = IDLE;
            end else begin
               ovf_d    = ovf_q | drop_s;
               pflush_d = pflush_q | flush;
            end
         end
         IDLE, FILL: begin
            if (close_s && free_s) begin
               frame_d  = {frame_type(ovf_q, flush), cnt_nx_s, buf_nx_s};
               load_s   = 1'b1;
               buf_d    = 30'd0;
               cnt_d    = 4'd0;
               ovf_d    = 1'b0;
               pflush_d = 1'b0;
               state_d  = IDLE;
            end else if (close_s) begin
               buf_d    = buf_nx_s;
               cnt_d    = cnt_nx_s;
               pflush_d = flush;
               state_d  = PEND;
            end else begin
               buf_d    = buf_nx_s;
               cnt_d    = cnt_nx_s;
               state_d  = (cnt_nx_s != 4'd0) ? FILL : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load_s) begin
         vld_d = 1'b1;
      end else if (itm_ready) begin
         vld_d = 1'b0;
      end else begin
         vld_d = vld_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         buf_q    <= 30'd0;
         cnt_q    <= 4'd0;
         ovf_q    <= 1'b0;
         pflush_q <= 1'b0;
         vld_q    <= 1'b0;
         frame_q  <= 36'd0;
         drop_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         buf_q    <= buf_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         pflush_q <= pflush_d;
         vld_q    <= vld_d;
         frame_q  <= frame_d;
         drop_q   <= drop_d;
      end
   end

   assign itm_valid  = vld_q;
   assign itm_frame  = frame_q;
   assign dct_buffer = buf_q;
   assign dct_count  = cnt_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_final_fpga_cpu_oci_dct_packer.sv
// Randomized and directed bench for the DCT packer against a queue-based frame model.
module tb_final_fpga_cpu_oci_dct_packer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        trace_en = 1'b0, dct_valid = 1'b0, dct_taken = 1'b0, flush = 1'b0, itm_ready = 1'b0;
   logic        itm_valid;
   logic [35:0] itm_frame;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic [7:0]  drop_cnt;
   logic [78:0] obs_s;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   int          mq[$];
   bit          m_pend, m_pflush, m_ovf, m_v;
   logic [35:0] m_frame;
   int          m_drop;
   int          issued, handed;

   final_fpga_cpu_oci_dct_packer #(.DEPTH(15), .SAT_MAX(255)) dut (
      .clk(clk), .reset(reset), .trace_en(trace_en), .dct_valid(dct_valid),
      .dct_taken(dct_taken), .flush(flush), .itm_ready(itm_ready),
      .itm_valid(itm_valid), .itm_frame(itm_frame), .dct_buffer(dct_buffer),
      .dct_count(dct_count), .drop_cnt(drop_cnt)
   );

   assign obs_s = {itm_valid, itm_frame, dct_buffer, dct_count, drop_cnt};

   always #5 clk = ~clk;

   function automatic logic [29:0] pack_q();
      logic [29:0] b = 30'd0;
      foreach (mq[i]) b = (b << 2) | 30'(mq[i]);
      return b;
   endfunction

   function automatic logic [78:0] exp_vec();
      return {m_v, m_frame, pack_q(), 4'(mq.size()), 8'(m_drop)};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pend = 0; m_pflush = 0; m_ovf = 0; m_v = 0; m_frame = 36'd0; m_drop = 0;
      issued = 0; handed = 0;
   endtask

   task automatic emit(input logic [1:0] ty);
      m_frame = {ty, 4'(mq.size()), pack_q()};
      mq.delete();
      m_pend = 0; m_ovf = 0; m_pflush = 0;
   endtask

   // Drive one cycle of inputs, advance the model, clock, and settle.
   task automatic step(input logic te, input logic dv, input logic dt, input logic fl, input logic rdy);
      bit free, load, drop;
      trace_en = te; dct_valid = dv; dct_taken = dt; flush = fl; itm_ready = rdy;
      if (te && dv) issued++;
      if (itm_valid && rdy) handed += int'(itm_frame[33:30]);
      free = !m_v || rdy; load = 0; drop = 0;
      if (m_pend) begin
         if (te && dv) begin
            drop = 1;
            if (m_drop < 255) m_drop++;
         end
         if (free) begin
            emit((m_ovf || drop) ? 2'b11 : (m_pflush || fl) ? 2'b10 : 2'b01);
            load = 1;
         end else begin
            if (drop) m_ovf = 1;
            if (fl) m_pflush = 1;
         end
      end else begin
         if (te && dv) mq.push_back(dt ? 2 : 1);
         if (mq.size() == 15 || (fl && mq.size() > 0)) begin
            if (free) begin
               emit(m_ovf ? 2'b11 : fl ? 2'b10 : 2'b01);
               load = 1;
            end else begin
               m_pend = 1;
               m_pflush = fl;
            end
         end
      end
      if (load) m_v = 1;
      else if (rdy) m_v = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      trace_en = 0; dct_valid = 0; dct_taken = 0; flush = 0; itm_ready = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (obs_s !== 79'd0) begin
         n_fail++; $display("FAIL reset_state: got %h expected 0", obs_s);
      end
      do_reset();
   endtask

   task automatic test_full_frame();
      logic [35:0] e;
      e = {2'b01, 4'hF, 30'h26666666};
      do_reset();
      for (int i = 0; i < 15; i++) begin
         step(1, 1, (i % 2 == 0), 0, 1);
         n_checks++;
         if (obs_s !== exp_vec()) begin
            n_fail++; $display("FAIL full_frame c%0d: got %h expected %h", i, obs_s, exp_vec());
         end
      end
      n_checks++;
      if ({itm_valid, itm_frame, dct_count} !== {1'b1, e, 4'd0}) begin
         n_fail++; $display("FAIL full_frame_value: got %b %h %0d expected 1 %h 0", itm_valid, itm_frame, dct_count, e);
      end
      step(1, 0, 0, 0, 1);
      n_checks++;
      if (itm_valid !== 1'b0) begin
         n_fail++; $display("FAIL full_frame_drain: got %b expected 0", itm_valid);
      end
   endtask

   task automatic test_flush();
      logic [35:0] e;
      e = {2'b10, 4'd3, 30'h00000029};
      do_reset();
      step(1, 1, 1, 0, 1);
      step(1, 1, 1, 0, 1);
      step(1, 1, 0, 0, 1);
      step(1, 0, 0, 1, 1);
      n_checks++;
      if ({itm_valid, itm_frame} !== {1'b1, e}) begin
         n_fail++; $display("FAIL flush_frame: got %b %h expected 1 %h", itm_valid, itm_frame, e);
      end
      step(1, 0, 0, 1, 1);
      n_checks++;
      if (itm_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_empty: got valid %b expected 0", itm_valid);
      end
      n_checks++;
      if (obs_s !== exp_vec()) begin
         n_fail++; $display("FAIL flush_model: got %h expected %h", obs_s, exp_vec());
      end
   endtask

   task automatic test_overflow();
      logic [35:0] a;
      a = {2'b10, 4'd1, 30'd2};
      do_reset();
      step(1, 1, 1, 1, 0);
      for (int i = 0; i < 19; i++) begin
         step(1, 1, 1'($urandom_range(0, 1)), 0, 0);
         n_checks++;
         if ({itm_valid, itm_frame} !== {1'b1, a} || obs_s !== exp_vec()) begin
            n_fail++; $display("FAIL overflow_hold c%0d: got %h expected %h", i, obs_s, exp_vec());
         end
      end
      n_checks++;
      if (drop_cnt !== 8'd4) begin
         n_fail++; $display("FAIL overflow_drops: got %0d expected 4", drop_cnt);
      end
      step(1, 0, 0, 0, 1);
      n_checks++;
      if ({itm_valid, itm_frame[35:30], dct_count} !== {1'b1, 2'b11, 4'hF, 4'd0} || obs_s !== exp_vec()) begin
         n_fail++; $display("FAIL overflow_type: got %h expected %h", obs_s, exp_vec());
      end
      step(1, 0, 0, 0, 1);
      n_checks++;
      if (itm_valid !== 1'b0) begin
         n_fail++; $display("FAIL overflow_drain: got %b expected 0", itm_valid);
      end
   endtask

   task automatic test_event_with_flush();
      logic [35:0] e;
      e = {2'b10, 4'd3, 30'h26};
      do_reset();
      step(1, 1, 1, 0, 1);
      step(1, 1, 0, 0, 1);
      step(1, 1, 1, 1, 1);
      n_checks++;
      if ({itm_valid, itm_frame} !== {1'b1, e} || obs_s !== exp_vec()) begin
         n_fail++; $display("FAIL event_flush: got %b %h expected 1 %h", itm_valid, itm_frame, e);
      end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      step(1, 1, 0, 1, 0);
      for (int i = 0; i < 7; i++) step(1, 1, 1'($urandom_range(0, 1)), 0, 0);
      n_checks++;
      if ({itm_valid, dct_count} !== {1'b1, 4'd7} || obs_s !== exp_vec()) begin
         n_fail++; $display("FAIL midframe_setup: got %h expected %h", obs_s, exp_vec());
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (obs_s !== 79'd0) begin
         n_fail++; $display("FAIL midframe_reset: got %h expected 0", obs_s);
      end
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 0);
         n_checks++;
         if (itm_valid !== 1'b0 || obs_s !== exp_vec()) begin
            n_fail++; $display("FAIL midframe_after c%0d: got %h expected %h", i, obs_s, exp_vec());
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      step(1, 1, 0, 1, 0);
      for (int i = 0; i < 275; i++) step(1, 1, 1'($urandom_range(0, 1)), 0, 0);
      n_checks++;
      if (drop_cnt !== 8'd255 || obs_s !== exp_vec()) begin
         n_fail++; $display("FAIL saturation: got %0d expected 255 (%h vs %h)", drop_cnt, obs_s, exp_vec());
      end
   endtask

   task automatic test_back_to_back();
      logic rdy;
      do_reset();
      for (int i = 0; i < 2400; i++) begin
         rdy = (i < 1200) ? 1'(i % 2) : 1'($urandom_range(0, 3) != 0);
         step(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), rdy);
         n_checks++;
         if (obs_s !== exp_vec()) begin
            n_fail++; $display("FAIL back_to_back c%0d: got %h expected %h", i, obs_s, exp_vec());
         end
      end
      if (m_drop < 255) begin
         n_checks++;
         if (handed + int'(drop_cnt) + int'(dct_count) + (itm_valid ? int'(itm_frame[33:30]) : 0) !== issued) begin
            n_fail++; $display("FAIL event_conservation: got %0d expected %0d",
                               handed + int'(drop_cnt) + int'(dct_count) + (itm_valid ? int'(itm_frame[33:30]) : 0), issued);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_flush();
      test_overflow();
      test_event_with_flush();
      test_reset_midframe();
      test_saturation();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
